// File: rtl/spi_flash_arbiter_if.sv
// Bus bundle between the SPI flash arbiter, its two masters and the flash pads.
// Index 0 is the USB-to-SPI bridge and index 1 is the on-chip flash client.
interface spi_flash_arbiter_if;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] m_cs_b;
    logic [1:0] m_sck;
    logic [1:0] m_mosi;
    logic [1:0] m_miso;
    logic       spi_cs_b;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;
    logic       busy;
    logic       timeout;
    logic       timeout_src;

    // Arbiter side.
    modport slave (
        input  req,
        input  m_cs_b,
        input  m_sck,
        input  m_mosi,
        input  spi_miso,
        output grant,
        output m_miso,
        output spi_cs_b,
        output spi_sck,
        output spi_mosi,
        output busy,
        output timeout,
        output timeout_src
    );

    // Masters plus flash pads, seen from outside the arbiter.
    modport master (
        output req,
        output m_cs_b,
        output m_sck,
        output m_mosi,
        output spi_miso,
        input  grant,
        input  m_miso,
        input  spi_cs_b,
        input  spi_sck,
        input  spi_mosi,
        input  busy,
        input  timeout,
        input  timeout_src
    );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Round-robin, transaction-atomic arbiter sharing one SPI flash between two masters,
// with a chip-select deselect guard and a hold-time watchdog.
module spi_flash_arbiter #(
    parameter int unsigned GUARD_CYCLES = 4,
    parameter logic [23:0] HOLD_TIMEOUT = 24'd12000000
) (
    input  logic                clk,
    input  logic                reset_n,
    spi_flash_arbiter_if.slave  bus
);

    localparam int unsigned GuardW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [GuardW-1:0] GuardLoad = GuardW'(GUARD_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StOwn,
        StGuard
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        lockout_q, lockout_d;
    logic              owner_q, owner_d;
    logic              cs_b_q, cs_b_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [23:0]       wdog_q, wdog_d;
    logic [GuardW-1:0] guard_q, guard_d;
    logic              timeout_q, timeout_d;
    logic              timeout_src_q, timeout_src_d;

    logic [1:0] eligible;
    logic       winner;
    logic       release_ok;
    logic       expired;

    assign eligible = bus.req & ~lockout_q;
    // On a tie the master that did not own the bus last wins.
    assign winner     = (eligible == 2'b11) ? ~owner_q : eligible[1];
    assign release_ok = ~bus.req[owner_q] & bus.m_cs_b[owner_q];
    assign expired    = (HOLD_TIMEOUT != 24'd0) && (wdog_q == (HOLD_TIMEOUT - 24'd1));

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        cs_b_d        = 1'b1;
        sck_d         = 1'b0;
        mosi_d        = 1'b0;
        wdog_d        = wdog_q;
        guard_d       = guard_q;
        timeout_d     = 1'b0;
        timeout_src_d = timeout_src_q;
        lockout_d     = lockout_q & bus.req;

        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d = StOwn;
                    grant_d = 2'b01 << winner;
                    owner_d = winner;
                    wdog_d  = '0;
                end
            end

            StOwn: begin
                cs_b_d = bus.m_cs_b[owner_q];
                sck_d  = bus.m_sck[owner_q];
                mosi_d = bus.m_mosi[owner_q];
                wdog_d = wdog_q + 24'd1;
                if (release_ok || expired) begin
                    grant_d = 2'b00;
                    cs_b_d  = 1'b1;
                    sck_d   = 1'b0;
                    mosi_d  = 1'b0;
                    // A clean release in the expiry cycle is not a timeout.
                    if (!release_ok) begin
                        timeout_d          = 1'b1;
                        timeout_src_d      = owner_q;
                        lockout_d[owner_q] = 1'b1;
                    end
                    if (release_ok && (GUARD_CYCLES == 0)) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StGuard;
                        guard_d = GuardLoad;
                    end
                end
            end

            StGuard: begin
                // Entered with a zero load only after a timeout with no guard configured.
                guard_d = (guard_q != '0) ? (guard_q - GuardW'(1)) : '0;
                if (guard_q <= GuardW'(1)) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            grant_q       <= 2'b00;
            lockout_q     <= 2'b00;
            owner_q       <= 1'b1;
            cs_b_q        <= 1'b1;
            sck_q         <= 1'b0;
            mosi_q        <= 1'b0;
            wdog_q        <= '0;
            guard_q       <= '0;
            timeout_q     <= 1'b0;
            timeout_src_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            lockout_q     <= lockout_d;
            owner_q       <= owner_d;
            cs_b_q        <= cs_b_d;
            sck_q         <= sck_d;
            mosi_q        <= mosi_d;
            wdog_q        <= wdog_d;
            guard_q       <= guard_d;
            timeout_q     <= timeout_d;
            timeout_src_q <= timeout_src_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.m_miso      = grant_q & {2{bus.spi_miso}};
    assign bus.spi_cs_b    = cs_b_q;
    assign bus.spi_sck     = sck_q;
    assign bus.spi_mosi    = mosi_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.timeout     = timeout_q;
    assign bus.timeout_src = timeout_src_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: grant edges checked against a scoreboard of expected
// (cycle, value) pairs, pad behaviour checked directly.
module tb_spi_flash_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    spi_flash_arbiter_if a_if ();
    spi_flash_arbiter_if b_if ();

    spi_flash_arbiter #(
        .GUARD_CYCLES (4),
        .HOLD_TIMEOUT (24'd100)
    ) u_dut_a (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (a_if)
    );

    spi_flash_arbiter #(
        .GUARD_CYCLES (0),
        .HOLD_TIMEOUT (24'd0)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (b_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      tag;
        int         cyc;
        logic [1:0] grant;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       sb_e;
    logic [1:0] prev_grant = 2'b00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic sb_push(input string tag, input int c, input logic [1:0] g);
        exp_t e;
        e.tag   = tag;
        e.cyc   = c;
        e.grant = g;
        sb_q.push_back(e);
    endtask

    // Every change of DUT A's grant must match the next scoreboard entry.
    always @(negedge clk) begin
        if (a_if.grant !== prev_grant) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_grant", 32'(a_if.grant), 32'(prev_grant));
            end else begin
                sb_e = sb_q.pop_front();
                check_val({sb_e.tag, "_val"}, 32'(a_if.grant), 32'(sb_e.grant));
                check_val({sb_e.tag, "_cyc"}, cyc, sb_e.cyc);
            end
            prev_grant = a_if.grant;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "tb_spi_flash_arbiter stuck");
    end

    initial begin
        int t;
        int g1;
        int x;

        rst_n           = 1'b0;
        a_if.req        = 2'b00;
        a_if.m_cs_b     = 2'b11;
        a_if.m_sck      = 2'b00;
        a_if.m_mosi     = 2'b00;
        a_if.spi_miso   = 1'b0;
        b_if.req        = 2'b00;
        b_if.m_cs_b     = 2'b11;
        b_if.m_sck      = 2'b00;
        b_if.m_mosi     = 2'b00;
        b_if.spi_miso   = 1'b0;

        // Reset values.
        tick(2);
        check_val("rst_grant", 32'(a_if.grant), 32'h0);
        check_val("rst_cs_b", 32'(a_if.spi_cs_b), 32'h1);
        check_val("rst_sck", 32'(a_if.spi_sck), 32'h0);
        check_val("rst_busy", 32'(a_if.busy), 32'h0);
        check_val("rst_timeout", 32'(a_if.timeout), 32'h0);
        check_val("rst_tsrc", 32'(a_if.timeout_src), 32'h0);
        rst_n = 1'b1;

        // Single master: latency, pass-through and release.
        run_to(10);
        a_if.req = 2'b01;
        sb_push("single_grant", 11, 2'b01);
        tick(2);
        a_if.m_cs_b[0] = 1'b0;
        tick(1);
        check_val("single_cs_low", 32'(a_if.spi_cs_b), 32'h0);
        check_val("single_busy", 32'(a_if.busy), 32'h1);
        a_if.spi_miso  = 1'b1;
        a_if.m_mosi[0] = 1'b1;
        a_if.m_sck[0]  = 1'b1;
        #1;
        check_val("single_miso", 32'(a_if.m_miso), 32'h1);
        tick(1);
        check_val("single_mosi", 32'(a_if.spi_mosi), 32'h1);
        check_val("single_sck", 32'(a_if.spi_sck), 32'h1);
        a_if.spi_miso  = 1'b0;
        a_if.m_mosi[0] = 1'b0;
        a_if.m_sck[0]  = 1'b0;
        a_if.m_cs_b[0] = 1'b1;
        a_if.req       = 2'b00;
        sb_push("single_release", cyc + 1, 2'b00);
        tick(1);
        check_val("single_rel_cs", 32'(a_if.spi_cs_b), 32'h1);
        check_val("single_guard_busy", 32'(a_if.busy), 32'h1);
        tick(6);
        check_val("single_idle_busy", 32'(a_if.busy), 32'h0);

        // Round-robin from reset with guard spacing.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        t = cyc;
        a_if.req = 2'b11;
        sb_push("rr_first", t + 1, 2'b01);
        tick(2);
        a_if.m_cs_b[0] = 1'b0;
        tick(2);
        a_if.m_cs_b[0] = 1'b1;
        a_if.req[0]    = 1'b0;
        sb_push("rr_rel0", t + 5, 2'b00);
        sb_push("rr_second", t + 10, 2'b10);
        tick(1);
        check_val("rr_guard_cs", 32'(a_if.spi_cs_b), 32'h1);
        check_val("rr_guard_busy", 32'(a_if.busy), 32'h1);
        run_to(t + 11);
        a_if.req[1] = 1'b0;
        sb_push("rr_rel1", t + 12, 2'b00);
        tick(1);
        a_if.req = 2'b11;
        sb_push("rr_third", t + 17, 2'b01);

        // Owner drops req with cs low: grant held, other master ignored.
        run_to(t + 18);
        a_if.m_cs_b = 2'b00;
        tick(1);
        a_if.req[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check_val("hold_grant", 32'(a_if.grant), 32'h1);
            check_val("hold_cs", 32'(a_if.spi_cs_b), 32'h0);
        end
        a_if.m_cs_b[0] = 1'b1;
        sb_push("hold_release", t + 25, 2'b00);
        sb_push("hold_next", t + 30, 2'b10);
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check_val("guard_no_cs", 32'(a_if.spi_cs_b), 32'h1);
        end
        tick(1);
        check_val("m1_cs_low", 32'(a_if.spi_cs_b), 32'h0);

        // Watchdog: master 1 holds cs low past HOLD_TIMEOUT.
        g1 = t + 30;
        sb_push("wdog_drop", g1 + 100, 2'b00);
        run_to(g1 + 99);
        check_val("wdog_pre_timeout", 32'(a_if.timeout), 32'h0);
        tick(1);
        check_val("wdog_timeout", 32'(a_if.timeout), 32'h1);
        check_val("wdog_tsrc", 32'(a_if.timeout_src), 32'h1);
        check_val("wdog_cs", 32'(a_if.spi_cs_b), 32'h1);
        tick(1);
        check_val("wdog_pulse_end", 32'(a_if.timeout), 32'h0);
        check_val("wdog_tsrc_kept", 32'(a_if.timeout_src), 32'h1);
        tick(12);
        check_val("lockout_no_grant", 32'(a_if.grant), 32'h0);
        check_val("lockout_idle", 32'(a_if.busy), 32'h0);
        x = cyc;
        a_if.req[1] = 1'b0;
        sb_push("lockout_regrant", x + 2, 2'b10);
        tick(1);
        a_if.req[1] = 1'b1;
        tick(1);
        a_if.m_cs_b[1] = 1'b1;
        a_if.req[1]    = 1'b0;
        sb_push("lockout_release", x + 3, 2'b00);
        tick(7);

        // Asynchronous reset in the middle of an owned transaction.
        x = cyc;
        a_if.req = 2'b01;
        sb_push("arst_grant", x + 1, 2'b01);
        tick(2);
        a_if.m_cs_b[0] = 1'b0;
        tick(2);
        check_val("arst_pre_cs", 32'(a_if.spi_cs_b), 32'h0);
        sb_push("arst_drop", cyc, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_cs", 32'(a_if.spi_cs_b), 32'h1);
        check_val("arst_grant0", 32'(a_if.grant), 32'h0);
        check_val("arst_busy", 32'(a_if.busy), 32'h0);
        a_if.req    = 2'b00;
        a_if.m_cs_b = 2'b11;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        x = cyc;
        a_if.req = 2'b11;
        sb_push("arst_after", x + 1, 2'b01);
        tick(2);
        a_if.req = 2'b00;
        sb_push("arst_after_rel", x + 3, 2'b00);
        tick(7);

        // No guard: back-to-back handover on DUT B.
        x = cyc;
        b_if.req = 2'b01;
        tick(1);
        check_val("ng_grant0", 32'(b_if.grant), 32'h1);
        tick(1);
        b_if.req = 2'b10;
        tick(1);
        check_val("ng_gap_grant", 32'(b_if.grant), 32'h0);
        check_val("ng_gap_busy", 32'(b_if.busy), 32'h0);
        tick(1);
        check_val("ng_grant1", 32'(b_if.grant), 32'h2);
        check_val("ng_grant1_busy", 32'(b_if.busy), 32'h1);
        check_val("ng_grant1_cyc", cyc, x + 4);
        b_if.req = 2'b00;
        tick(1);
        check_val("ng_rel_grant", 32'(b_if.grant), 32'h0);
        check_val("ng_rel_busy", 32'(b_if.busy), 32'h0);

        tick(2);
        check_val("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
